aes_128_inv_subbytes_seq: RTL and testbench
===========================================

// Module: aes_128_inv_subbytes_seq
// PURPOSE
// - Decrypt-path counterpart of the encrypt SubBytes/ShiftRows stage. Computes InvShiftRows + InvSubBytes on one 128-bit state.
// - Uses LANES inverse S-box lookups per cycle from a synchronous ROM, so one state takes 16/LANES lookup beats.
// - Has valid/ready on both sides. Sits between AddRoundKey/InvMixColumns and the decrypt round register.
// PARAMETERS
// - LANES  4  bytes looked up per cycle. Legal values: 2, 4, 8, 16. Even, because the ROM is dual-port.
// - NBEAT  16/LANES  derived localparam, never overridden. Lookup beats per state.
// PORTS
// - clk        in   1    single clock; all logic rising-edge.
// - rst_n      in   1    asynchronous, active-low reset.
// - kill       in   1    synchronous abort; flushes the block.
// - in_valid   in   1    in_data is valid.
// - in_ready   out  1    block can accept a state.
// - in_data    in   128  state; byte i = in_data[8i+7:8i]; row r = i%4, column c = i/4.
// - out_valid  out  1    out_data is valid.
// - out_ready  in   1    downstream accepts out_data.
// - out_data   out  128  result, same byte layout as in_data.
// BEHAVIOUR
// - Function: out byte (r+4c) = InvSbox(in byte (r + 4*((c-r) mod 4))).
//   Example: out byte1 <- in byte13, out byte2 <- in byte10, out byte3 <- in byte7.
// - Reset (rst_n=0): state=IDLE, beat counter=0, out_valid=0, out_data=0, ROM outputs=0.
//   in_ready is decoded from state, so it reads 1 after reset.
// - FSM states IDLE, LOOK, DRAIN, HOLD.
//   - IDLE: in_ready=1. When in_valid && in_ready, capture in_data into src_q, clear beat counter, go to LOOK.
//   - LOOK: issue ROM addresses for out bytes [beat*LANES +: LANES] from src_q via the inverse-shift map.
//     Counter increments each cycle. On beat NBEAT-1, go to DRAIN.
//   - DRAIN: one cycle so the last ROM read returns (ROM latency = 1). Set out_valid at the end of this cycle. Go to HOLD.
//   - HOLD: out_valid=1, out_data stable. When out_ready, clear out_valid and go to IDLE.
// - ROM results are written into out_data[(beat-1)*LANES*8 +: LANES*8] one cycle after the address beat. A delayed-beat register tracks this.
// - Latency: out_valid is 1 exactly NBEAT+2 rising edges after the accepting edge (6 for LANES=4).
// - Throughput: one state per NBEAT+3 cycles when out_ready is held at 1. No overlap: in_ready=0 outside IDLE.
// - Backpressure: out_valid and out_data hold indefinitely while out_ready=0. in_ready stays 0 during this time.
// - Completion in HOLD returns to IDLE, so in_ready first reads 1 on the next cycle. Same-cycle out/in handshake is not allowed.
// - kill has priority over every other event, in any state:
//   - next edge: state=IDLE, out_valid=0, counter=0.
//   - out_data is not cleared. It is don't-care while out_valid=0.
//   - An in_valid in the same cycle as kill is ignored.
// - rst_n asserted mid-operation: immediate async return to reset values. The partial state is discarded.
// - The ROM enable is active only in LOOK, which keeps BRAM toggling low.
// STRUCTURE
// - Package aes_128_pkg:
//   - INV_SBOX[256] constant table.
//   - function inv_shift_src(idx) returning the source byte index.
//   - FSM state encoding typedef.
// - Sub-module aes_128_inv_sbox_rom: dual-read-port 256x8 synchronous ROM with per-port enable and 1-cycle latency.
//   Instantiate LANES/2 copies.
// - Top level holds src_q, the FSM, the beat counter and the output assembly register.
// TESTING
// - Reset check: after rst_n release, in_ready=1, out_valid=0, out_data=0.
// - All-bytes 0x63 in, out_ready=1: out_data=128'h0 exactly 6 edges after accept (LANES=4).
// - All-bytes 0x00 in: out_data all 0x52.
//   Byte 13=0x7C with all other bytes 0x63: out byte1=0x01, all other bytes 0x00 (checks shift direction).
// - Round trip: 1000 random X through aes_128_subbytes, then this block, must return X.
//   Random in_valid gaps and random out_ready stalls; out_data must stay stable while stalled.
// - kill pulse in LOOK beat 2, and again in HOLD: out_valid drops next edge, in_ready=1.
//   A new state accepted afterwards gives a correct result.
// - rst_n pulse mid-LOOK: reset values immediately. Rerun with LANES=2: latency 10 edges, same vectors pass.

Source files
------------

// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared AES decrypt-path definitions
//   INV_SBOX      : 256-entry inverse S-box, indexed by the byte to invert
//   inv_shift_src : InvShiftRows map, output byte index -> source byte index
//   state_t       : FSM encoding for the inverse SubBytes/ShiftRows stage
package aes_128_pkg;

   typedef enum logic [1:0] {IDLE, LOOK, DRAIN, HOLD} state_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Byte idx sits at row idx[1:0], column idx[3:2]; InvShiftRows pulls it
   // from column (c - r) mod 4 of the same row.
   function automatic logic [3:0] inv_shift_src(input logic [3:0] idx);
      logic [1:0] c;
      c = idx[3:2] - idx[1:0];
      return {c, idx[1:0]};
   endfunction

endpackage

// File: rtl/aes_128_inv_sbox_rom.sv
// aes_128_inv_sbox_rom: dual-read-port 256x8 inverse S-box ROM, 1-cycle latency
//   clk, rst_n       : clock, async active-low reset (clears read data)
//   en_a, addr_a     : port A enable and address
//   en_b, addr_b     : port B enable and address
//   data_a, data_b   : registered read data, held while the port is disabled
module aes_128_inv_sbox_rom
   import aes_128_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_a,
   input  logic [7:0] addr_a,
   input  logic       en_b,
   input  logic [7:0] addr_b,
   output logic [7:0] data_a,
   output logic [7:0] data_b
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         data_a <= '0;
         data_b <= '0;
      end else begin
         if (en_a) data_a <= INV_SBOX[addr_a];
         if (en_b) data_b <= INV_SBOX[addr_b];
      end

endmodule

// File: rtl/aes_128_inv_subbytes_seq.sv
// aes_128_inv_subbytes_seq: InvShiftRows + InvSubBytes on one 128-bit state, LANES bytes per beat
//   clk, rst_n            : clock, async active-low reset
//   kill                  : synchronous abort, returns to IDLE
//   in_valid/in_ready     : input handshake, in_data byte i = in_data[8i+7:8i]
//   out_valid/out_ready   : output handshake, out_data uses the same byte layout
module aes_128_inv_subbytes_seq
   import aes_128_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         kill,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int NBEAT = 16 / LANES;
   localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

   state_t              state;
   logic [127:0]        src_q;
   logic [BW-1:0]       beat;
   logic [BW-1:0]       beat_d;
   logic                wr_q;
   logic                rom_en;
   logic [7:0]          addr  [LANES];
   logic [7:0]          rdata [LANES];
   logic [LANES*8-1:0]  rd_flat;

   assign in_ready = state == IDLE;
   assign rom_en   = state == LOOK;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign addr[l] = src_q[{inv_shift_src(4'(int'(beat) * LANES + l)), 3'b000} +: 8];
      assign rd_flat[8*l +: 8] = rdata[l];
   end

   for (genvar p = 0; p < LANES / 2; p++) begin : g_rom
      aes_128_inv_sbox_rom u_rom (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_a   (rom_en),
         .addr_a (addr[2*p]),
         .en_b   (rom_en),
         .addr_b (addr[2*p+1]),
         .data_a (rdata[2*p]),
         .data_b (rdata[2*p+1])
      );
   end

   // wr_q/beat_d trail the address beat by one cycle to line up with ROM data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         src_q     <= '0;
         beat      <= '0;
         beat_d    <= '0;
         wr_q      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (kill) begin
         state     <= IDLE;
         beat      <= '0;
         wr_q      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         wr_q   <= state == LOOK;
         beat_d <= beat;
         if (wr_q) out_data[7'(int'(beat_d) * LANES * 8) +: LANES*8] <= rd_flat;
         case (state)
            IDLE:
               if (in_valid) begin
                  src_q <= in_data;
                  beat  <= '0;
                  state <= LOOK;
               end
            LOOK:
               if (beat == BW'(NBEAT - 1)) begin
                  beat  <= '0;
                  state <= DRAIN;
               end else begin
                  beat  <= beat + 1'b1;
               end
            DRAIN: begin
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_aes_128_inv_subbytes_seq.sv
// tb_aes_128_inv_subbytes_seq: directed and round-trip checks of the inverse SubBytes/ShiftRows stage
module tb_aes_128_inv_subbytes_seq;

   localparam int LANES = 4;
   localparam int NBEAT = 16 / LANES;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic         clk = 1'b0;
   logic         rst_n;
   logic         kill;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int total = 0;
   int bad   = 0;

   aes_128_inv_subbytes_seq #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kill      (kill),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Encrypt-side SubBytes then ShiftRows: the stage under test must undo it.
   function automatic logic [127:0] fwd(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++)
         y[8*i +: 8] = SBOX[x[8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) +: 8]];
      return y;
   endfunction

   task automatic send(input logic [127:0] x);
      int n;
      n = 0;
      in_data  = x;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Latency counts the accepting edge as edge 1.
   task automatic xfer(input string tag, input logic [127:0] x, input logic [127:0] exp, input int stall);
      int n;
      send(x);
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, NBEAT + 2);
      chk({tag, "_data"}, out_data, exp);
      if (stall > 0) begin
         repeat (stall) begin @(posedge clk); #1; end
         chk({tag, "_stall_v"}, out_valid, 1);
         chk({tag, "_stall_d"}, out_data, exp);
      end
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_clr"}, out_valid, 0);
      chk({tag, "_ir_back"}, in_ready, 1);
   endtask

   initial begin
      logic [127:0] x;
      logic [127:0] d;
      rst_n     = 1'b0;
      kill      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);

      xfer("all63", {16{8'h63}}, 128'h0, 2);
      take("all63");
      xfer("all00", 128'h0, {16{8'h52}}, 0);
      take("all00");
      d = {16{8'h63}};
      d[111:104] = 8'h7c;
      xfer("shift_dir", d, 128'h0100, 1);
      take("shift_dir");

      // kill during LOOK beat 2, with a competing in_valid that must be ignored
      send({16{8'h11}});
      repeat (2) begin @(posedge clk); #1; end
      kill = 1'b1;
      in_valid = 1'b1;
      in_data = 128'h0;
      @(posedge clk); #1;
      kill = 1'b0;
      in_valid = 1'b0;
      chk("kill_look_ov", out_valid, 0);
      chk("kill_look_ir", in_ready, 1);
      repeat (10) begin @(posedge clk); #1; end
      chk("kill_look_quiet", out_valid, 0);
      xfer("after_kill_look", 128'h0, {16{8'h52}}, 0);
      take("after_kill_look");

      // kill while holding a result
      xfer("pre_kill_hold", d, 128'h0100, 0);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_hold_ov", out_valid, 0);
      chk("kill_hold_ir", in_ready, 1);
      x = {$urandom, $urandom, $urandom, $urandom};
      xfer("after_kill_hold", fwd(x), x, 1);
      take("after_kill_hold");

      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         xfer("rt", fwd(x), x, int'($urandom_range(0, 3)));
         take("rt");
      end

      // async reset mid-LOOK takes effect without a clock edge
      send({16{8'h22}});
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ir", in_ready, 1);
      chk("arst_ov", out_valid, 0);
      chk("arst_od", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer("after_arst", {16{8'h63}}, 128'h0, 0);
      take("after_arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
